// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronizing button debouncer with edge and long-press pulses
//
// Purpose: synchronizes a raw, bouncing button level and accepts a level change
// only after it has been stable for DEBOUNCE_CYCLES further synchronized samples.
// It also reports accepted edges and a single long-press event per press.
//
// Ports:
//   clk         rising-edge system clock
//   rst         asynchronous, active-high reset
//   btn_in      raw asynchronous button level (may bounce)
//   btn_level   debounced, registered level
//   rise_pulse  one-cycle pulse on an accepted 0->1 change
//   fall_pulse  one-cycle pulse on an accepted 1->0 change
//   long_press  one-cycle pulse when a press has been held LONG_CYCLES cycles

module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic long_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONF_HI = 2'd1,
    HIGH    = 2'd2,
    CONF_LO = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] hold, hold_n;
  logic          sync1, s;
  logic          level_n, rise_n, fall_n, long_n;

  // Two-flop synchronizer; s is the only view of btn_in the rest of the block uses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= btn_in;
      s     <= sync1;
    end
  end

  // State, counters and outputs share one register so every output is registered
  // and changes on the same edge as the transition that causes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hold       <= '0;
      btn_level  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hold       <= hold_n;
      btn_level  <= level_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
      long_press <= long_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold_n  = hold;
    case (state)
      IDLE: begin
        if (s) begin
          state_n = CONF_HI;
          cnt_n   = CW'(1);
        end else begin
          cnt_n = '0;
        end
      end
      CONF_HI: begin
        if (!s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = HIGH;
          cnt_n   = '0;
          hold_n  = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_n = CONF_LO;
          cnt_n   = CW'(1);
        end else begin
          cnt_n = '0;
          // Saturating hold counter; it never moves once it hits the limit,
          // which is what keeps long_press from repeating within one press.
          if (hold != HOLD_MAX) hold_n = hold + HW'(1);
        end
      end
      CONF_LO: begin
        // hold is left untouched here so a short release resumes the count.
        if (s) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the transition being taken, then registered above.
  always_comb begin
    level_n = (state_n == HIGH) || (state_n == CONF_LO);
    rise_n  = (state == CONF_HI) && (state_n == HIGH);
    fall_n  = (state == CONF_LO) && (state_n == IDLE);
    long_n  = (hold != HOLD_MAX) && (hold_n == HOLD_MAX);
  end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - scoreboard bench for input_debouncer

module tb_input_debouncer;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_LONG = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  typedef struct packed {
    logic        s1;
    logic        s;
    logic        level;
    logic [15:0] run;
    logic [15:0] hold;
    logic        rise;
    logic        fall;
    logic        lng;
  } model_t;

  logic clk, rst, btn, btn_r;
  logic lvl0, rise0, fall0, long0;
  logic lvl2, rise2, fall2, long2;
  logic lvl7, rise7, fall7, long7;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  ev_t  exp_q[$];
  model_t m2, m7;
  logic up2, up7;

  input_debouncer u_dut (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_level(lvl0), .rise_pulse(rise0), .fall_pulse(fall0), .long_press(long0)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(2), .LONG_CYCLES(3)) u_d2 (
    .clk(clk), .rst(rst), .btn_in(btn_r),
    .btn_level(lvl2), .rise_pulse(rise2), .fall_pulse(fall2), .long_press(long2)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(7), .LONG_CYCLES(5)) u_d7 (
    .clk(clk), .rst(rst), .btn_in(btn_r),
    .btn_level(lvl7), .rise_pulse(rise7), .fall_pulse(fall7), .long_press(long7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pops the next expected event for an observed pulse on the default instance.
  task automatic mon_pop(input int kind, input logic lvl, input logic lvl_exp);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_pulse_kind", kind, 99);
    end else begin
      e = exp_q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.cyc);
      chk("level_at_pulse", lvl, lvl_exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rise0) mon_pop(K_RISE, lvl0, 1'b1);
      if (long0) mon_pop(K_LONG, lvl0, 1'b1);
      if (fall0) mon_pop(K_FALL, lvl0, 1'b0);
    end
  end

  // Reference: a level flips once the synchronized input has disagreed with it
  // for DEBOUNCE+1 consecutive samples; hold counts stable-high samples.
  function automatic model_t mstep(input model_t m, input logic b, input int d, input int l);
    model_t n;
    n      = m;
    n.s1   = b;
    n.s    = m.s1;
    n.rise = 1'b0;
    n.fall = 1'b0;
    n.lng  = 1'b0;
    n.run  = (m.s != m.level) ? m.run + 16'd1 : 16'd0;
    if (m.level && m.run == 0 && m.s && int'(m.hold) < l) begin
      n.hold = m.hold + 16'd1;
      if (int'(n.hold) == l) n.lng = 1'b1;
    end
    if (int'(n.run) == d + 1) begin
      n.run   = 16'd0;
      n.level = ~m.level;
      if (n.level) begin
        n.rise = 1'b1;
        n.hold = 16'd0;
      end else begin
        n.fall = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m2 <= '0;
      m7 <= '0;
    end else begin
      m2 <= mstep(m2, btn_r, 2, 3);
      m7 <= mstep(m7, btn_r, 7, 5);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      up2 = 1'b1;
      up7 = 1'b1;
    end else begin
      chk("model_d2", {28'd0, lvl2, rise2, fall2, long2}, {28'd0, m2.level, m2.rise, m2.fall, m2.lng});
      chk("model_d7", {28'd0, lvl7, rise7, fall7, long7}, {28'd0, m7.level, m7.rise, m7.fall, m7.lng});
      if (rise2) begin chk("alt_rise_d2", up2, 1'b1); up2 = 1'b0; end
      if (fall2) begin chk("alt_fall_d2", up2, 1'b0); up2 = 1'b1; end
      if (rise7) begin chk("alt_rise_d7", up7, 1'b1); up7 = 1'b0; end
      if (fall7) begin chk("alt_fall_d7", up7, 1'b0); up7 = 1'b1; end
    end
  end

  initial begin
    int t, d, dur;
    rst   = 1'b1;
    btn   = 1'b0;
    btn_r = 1'b0;
    up2   = 1'b1;
    up7   = 1'b1;
    #1;
    chk("reset_outputs", {28'd0, lvl0, rise0, fall0, long0}, 32'd0);
    chk("reset_level_d7", lvl7, 1'b0);
    wait_n(2);
    rst = 1'b0;
    wait_n(3);

    // Clean press held 40 cycles: rise after 7, long 16 after rise, then release.
    t = cyc; btn = 1'b1;
    push(K_RISE, t + 7);
    push(K_LONG, t + 23);
    wait_n(40);
    t = cyc; btn = 1'b0;
    push(K_FALL, t + 7);
    wait_n(12);

    // Short bounces: 3 high, 3 low, five times; nothing may be accepted.
    repeat (5) begin
      btn = 1'b1; wait_n(3);
      btn = 1'b0; wait_n(3);
    end
    wait_n(8);

    // Two-cycle dropout while high: no fall, hold resumes (3 edges lost).
    t = cyc; btn = 1'b1;
    push(K_RISE, t + 7);
    push(K_LONG, t + 26);
    wait_n(12);
    btn = 1'b0; wait_n(2);
    btn = 1'b1; wait_n(30);
    t = cyc; btn = 1'b0;
    push(K_FALL, t + 7);
    wait_n(12);

    // Asynchronous reset between edges while high, with the button still held.
    t = cyc; btn = 1'b1;
    push(K_RISE, t + 7);
    wait_n(10);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_level", lvl0, 1'b0);
    chk("async_reset_pulses", {29'd0, rise0, fall0, long0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    d = cyc;
    push(K_RISE, d + 7);
    wait_n(17);
    t = cyc; btn = 1'b0;
    push(K_FALL, t + 7);
    wait_n(12);
    chk("queue_empty_directed", exp_q.size(), 0);

    // Random bounce and glitch stimulus for the D=2 and D=7 instances.
    @(negedge clk); rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    for (int i = 0; i < 120; i++) begin
      dur = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(8, 25);
      btn_r = ~btn_r;
      wait_n(dur);
    end
    btn_r = 1'b0;
    wait_n(30);
    chk("queue_empty_final", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
